// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state encoding and default width for the ALU arbiter slice.
package alu_pkg;

  localparam int DW_DEF = 16;

  localparam logic [2:0] OP_ADD     = 3'b000;
  localparam logic [2:0] OP_INC     = 3'b001;
  localparam logic [2:0] OP_SMAX    = 3'b010;
  localparam logic [2:0] OP_ADDHALF = 3'b011;
  localparam logic [2:0] OP_AND     = 3'b100;
  localparam logic [2:0] OP_OR      = 3'b101;
  localparam logic [2:0] OP_NOT     = 3'b110;
  localparam logic [2:0] OP_ZERO    = 3'b111;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_EXEC = 2'd1;
  localparam state_t ST_RESP = 2'd2;

endpackage

// File: rtl/alu_exec.sv
// Combinational opcode evaluation: opc/a/b/cin -> result plus zero/negative flags.
// Zero latency, no flow control; carry-out is discarded for every opcode.
module alu_exec
  import alu_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [2:0]    opc,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          cin,
  output logic [DW-1:0] result,
  output logic          zer,
  output logic          neg
);

  always_comb begin
    result = '0;
    case (opc)
      OP_ADD:     result = a + b + {{(DW-1){1'b0}}, cin};
      OP_INC:     result = a + {{(DW-1){1'b0}}, 1'b1};
      // Ties resolve to a.
      OP_SMAX:    result = ($signed(a) < $signed(b)) ? b : a;
      OP_ADDHALF: result = a + (b >> 1);
      OP_AND:     result = a & b;
      OP_OR:      result = a | b;
      OP_NOT:     result = ~a;
      default:    result = '0;
    endcase
  end

  assign zer = (result == '0);
  assign neg = result[DW-1];

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester valid/ready arbiter sharing one ALU; one op in flight, handshake at T -> rsp_valid at T+2.
// Both readys stay low in EXEC/RESP; the response is held stable until rsp_ready.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter bit RR_EN = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [2:0]    req0_opc,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  input  logic          req0_cin,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [2:0]    req1_opc,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  input  logic          req1_cin,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_zer,
  output logic          rsp_neg,
  output logic          busy
);

  state_t        state_q, state_d;
  logic          rr_ptr_q;
  logic [2:0]    opc_q;
  logic [DW-1:0] a_q, b_q;
  logic          cin_q, id_q;
  logic          rsp_valid_q, rsp_id_q, rsp_zer_q, rsp_neg_q;
  logic [DW-1:0] rsp_data_q;

  logic          idle, pick1, hs;
  logic [DW-1:0] exe_res;
  logic          exe_zer, exe_neg;

  assign idle = (state_q == ST_IDLE);

  // req1 wins when alone, or on a tie when round-robin points at it.
  assign pick1      = req1_valid & (~req0_valid | (RR_EN & rr_ptr_q));
  assign req1_ready = idle & pick1;
  assign req0_ready = idle & req0_valid & ~pick1;
  assign hs         = req0_ready | req1_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (hs) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  alu_exec #(.DW(DW)) u_exec (
    .opc    (opc_q),
    .a      (a_q),
    .b      (b_q),
    .cin    (cin_q),
    .result (exe_res),
    .zer    (exe_zer),
    .neg    (exe_neg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= 1'b0;
      opc_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      id_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_zer_q   <= 1'b0;
      rsp_neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (hs) begin
        opc_q    <= req1_ready ? req1_opc : req0_opc;
        a_q      <= req1_ready ? req1_a   : req0_a;
        b_q      <= req1_ready ? req1_b   : req0_b;
        cin_q    <= req1_ready ? req1_cin : req0_cin;
        id_q     <= req1_ready;
        rr_ptr_q <= ~req1_ready;
      end
      if (state_q == ST_EXEC) begin
        rsp_valid_q <= 1'b1;
        rsp_id_q    <= id_q;
        rsp_data_q  <= exe_res;
        rsp_zer_q   <= exe_zer;
        rsp_neg_q   <= exe_neg;
      end else if (state_q == ST_RESP && rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_zer   = rsp_zer_q;
  assign rsp_neg   = rsp_neg_q;
  assign busy      = ~idle;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: round-robin instance is fully checked, a fixed-priority twin shares its inputs.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [2:0]  req0_opc = '0, req1_opc = '0;
  logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        req0_cin = 1'b0, req1_cin = 1'b0;
  logic        rsp_ready = 1'b1;

  logic        req0_ready, req1_ready, rsp_valid, rsp_id, rsp_zer, rsp_neg, busy;
  logic [15:0] rsp_data;
  logic        fp_req0_ready, fp_req1_ready, fp_rsp_valid, fp_rsp_id, fp_rsp_zer, fp_rsp_neg, fp_busy;
  logic [15:0] fp_rsp_data;

  typedef struct packed {
    logic        id;
    logic [15:0] data;
    logic        zer;
    logic        neg;
  } rsp_t;

  rsp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  logic fp_phase = 1'b0;
  int   fp_rsp_cnt = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DW(16), .RR_EN(1'b1)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opc(req0_opc),
    .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opc(req1_opc),
    .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_zer(rsp_zer), .rsp_neg(rsp_neg), .busy(busy)
  );

  alu_arbiter #(.DW(16), .RR_EN(1'b0)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_opc(req0_opc),
    .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_opc(req1_opc),
    .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(fp_rsp_id),
    .rsp_data(fp_rsp_data), .rsp_zer(fp_rsp_zer), .rsp_neg(fp_rsp_neg), .busy(fp_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every response handshake pops the oldest expected response.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      rsp_t got, e;
      got = {rsp_id, rsp_data, rsp_zer, rsp_neg};
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL rsp_unexpected: got id=%0d data=%h zer=%0d neg=%0d, expected no response",
                 got.id, got.data, got.zer, got.neg);
      end else begin
        e = sb.pop_front();
        if (got !== e) begin
          failures++;
          $display("FAIL rsp_check: got id=%0d data=%h zer=%0d neg=%0d, expected id=%0d data=%h zer=%0d neg=%0d",
                   got.id, got.data, got.zer, got.neg, e.id, e.data, e.zer, e.neg);
        end
      end
    end
  end

  // Fixed-priority twin: while both requesters contend, req1 must never be served.
  always @(negedge clk) begin
    if (fp_phase) begin
      chk("fp_req1_ready_low", fp_req1_ready, 0);
      if (fp_rsp_valid && rsp_ready) begin
        fp_rsp_cnt++;
        chk("fp_rsp_id_data", {fp_rsp_id, fp_rsp_data}, {1'b0, 16'hF000});
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_ready(input logic id);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if ((id ? req1_ready : req0_ready) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("accept_timeout", ok, 1);
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy && !fp_busy && sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_timeout", ok, 1);
  endtask

  task automatic send(input logic id, input logic [2:0] opc, input logic [15:0] a, input logic [15:0] b,
                      input logic cin, input logic [15:0] exp_d, input logic exp_z, input logic exp_n,
                      input bit exp_push);
    @(posedge clk);
    #1;
    if (id) begin
      req1_valid = 1'b1; req1_opc = opc; req1_a = a; req1_b = b; req1_cin = cin;
    end else begin
      req0_valid = 1'b1; req0_opc = opc; req0_a = a; req0_b = b; req0_cin = cin;
    end
    if (exp_push) sb.push_back({id, exp_d, exp_z, exp_n});
    wait_ready(id);
    @(posedge clk);
    #1;
    if (id) req1_valid = 1'b0;
    else    req0_valid = 1'b0;
  endtask

  initial begin
    int n;
    logic ok;

    // Reset state.
    rst_n = 1'b0;
    #12;
    chk("reset_outputs", {rsp_valid, busy, req0_ready, req1_ready, rsp_id, rsp_zer, rsp_neg, rsp_data},
        {7'b0, 16'h0000});
    @(posedge clk);
    #1 rst_n = 1'b1;

    // req0 add with carry, plus latency T -> T+2.
    @(posedge clk);
    #1;
    req0_valid = 1'b1; req0_opc = OP_ADD; req0_a = 16'h7FFF; req0_b = 16'h0001; req0_cin = 1'b1;
    sb.push_back({1'b0, 16'h8001, 1'b0, 1'b1});
    wait_ready(1'b0);
    chk("lat_T_valid", rsp_valid, 0);
    @(posedge clk);
    #1 req0_valid = 1'b0;
    @(negedge clk);
    chk("lat_T1_valid_busy", {rsp_valid, busy}, 2'b01);
    @(negedge clk);
    chk("lat_T2_valid", rsp_valid, 1);
    wait_idle();

    // Both valid from reset: round-robin alternates, fixed priority always picks req0.
    do_reset();
    @(posedge clk);
    #1;
    req0_valid = 1'b1; req0_opc = OP_AND; req0_a = 16'hF0F0; req0_b = 16'hFF00; req0_cin = 1'b0;
    req1_valid = 1'b1; req1_opc = OP_NOT; req1_a = 16'h0000; req1_b = 16'h0000; req1_cin = 1'b0;
    sb.push_back({1'b0, 16'hF000, 1'b0, 1'b1});
    sb.push_back({1'b1, 16'hFFFF, 1'b0, 1'b1});
    sb.push_back({1'b0, 16'hF000, 1'b0, 1'b1});
    sb.push_back({1'b1, 16'hFFFF, 1'b0, 1'b1});
    fp_phase = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) n++;
      if (n == 4) break;
    end
    chk("rr_accept_count", n, 4);
    @(posedge clk);
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle();
    #1 fp_phase = 1'b0;
    chk("fp_rsp_count", fp_rsp_cnt, 4);

    // Directed opcode vectors, alternating requesters.
    send(1'b0, OP_SMAX,    16'hFFFE, 16'h0003, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b1);
    send(1'b1, OP_ADDHALF, 16'h0010, 16'h8001, 1'b0, 16'h4010, 1'b0, 1'b0, 1'b1);
    send(1'b0, OP_ZERO,    16'hABCD, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    send(1'b1, OP_INC,     16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    send(1'b0, OP_SMAX,    16'h8000, 16'h7FFF, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1);
    send(1'b1, OP_SMAX,    16'h8005, 16'h8005, 1'b0, 16'h8005, 1'b0, 1'b1, 1'b1);
    send(1'b0, OP_ADD,     16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    send(1'b1, OP_ADD,     16'h1000, 16'h0234, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b1);
    send(1'b0, OP_NOT,     16'h00FF, 16'h0000, 1'b1, 16'hFF00, 1'b0, 1'b1, 1'b1);
    send(1'b1, OP_OR,      16'h1200, 16'h0034, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b1);
    send(1'b0, OP_ADDHALF, 16'h0001, 16'h0001, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b1);
    wait_idle();

    // Backpressure: response held stable, requests stall, next accept one cycle after release.
    rsp_ready = 1'b0;
    send(1'b0, OP_OR, 16'h00F0, 16'h0F00, 1'b0, 16'h0FF0, 1'b0, 1'b0, 1'b1);
    req1_valid = 1'b1; req1_opc = OP_NOT; req1_a = 16'h1234; req1_b = 16'h0000; req1_cin = 1'b0;
    sb.push_back({1'b1, 16'hEDCB, 1'b0, 1'b1});
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk("bp_valid_timeout", ok, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold", {rsp_valid, busy, req0_ready, req1_ready, rsp_id, rsp_zer, rsp_neg, rsp_data},
          {7'b1100000, 16'h0FF0});
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_no_accept_on_rsp_hs", req1_ready, 0);
    @(negedge clk);
    chk("bp_accept_next_cycle", req1_ready, 1);
    @(posedge clk);
    #1 req1_valid = 1'b0;
    wait_idle();

    // Reset during EXEC discards the op; round-robin pointer returns to req0.
    send(1'b0, OP_ADD, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("midop_reset_clear", {rsp_valid, busy, rsp_data}, {2'b00, 16'h0000});
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no_stale_rsp", rsp_valid, 0);
    end
    @(posedge clk);
    #1;
    req0_valid = 1'b1; req0_opc = OP_AND; req0_a = 16'hF0F0; req0_b = 16'hFF00; req0_cin = 1'b0;
    req1_valid = 1'b1; req1_opc = OP_NOT; req1_a = 16'h0000; req1_b = 16'h0000; req1_cin = 1'b0;
    sb.push_back({1'b0, 16'hF000, 1'b0, 1'b1});
    #1;
    chk("rr_ptr_after_reset", {req0_ready, req1_ready}, 2'b10);
    @(posedge clk);
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_idle();

    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one 16-bit ALU datapath between two requesters (req0, req1) using valid/ready handshakes.
- Registers the selected operation, executes it, and returns the result and flags on a single response channel tagged with the requester id.
- Sits between the two command sources (e.g. sequencer and DMA-side helper) and the ALU; one operation is in flight at a time.

Parameters:
- DW, 16, datapath width; only 16 is supported (opcode semantics are defined at 16 bits).
- RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority, req0 always wins.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_opc  in  3  requester 0 opcode
- req0_a, req0_b  in  16  requester 0 operands
- req0_cin  in  1  requester 0 carry-in
- req1_valid / req1_ready / req1_opc / req1_a / req1_b / req1_cin: same as req0, for requester 1
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  1  requester that issued the operation (0/1)
- rsp_data  out  16  ALU result
- rsp_zer  out  1  rsp_data == 0
- rsp_neg  out  1  rsp_data[15]
- busy  out  1  high in EXEC or RESP

Behaviour:
- Reset (async, rst_n=0): state=IDLE; rr_ptr=0; rsp_valid=0; rsp_id=0; rsp_data=0; rsp_zer=0; rsp_neg=0; busy=0; both req_ready=0. Any in-flight operation is discarded and no response is issued.
- States: IDLE -> EXEC -> RESP -> IDLE.
- IDLE, request selection:
  - If exactly one reqN_valid is high, that requester is granted.
  - If both are high: with RR_EN=1, the requester equal to rr_ptr wins; with RR_EN=0, req0 wins.
  - reqN_ready = (state==IDLE) & granted_N. It is combinational from the valids, and at most one ready is high.
- On handshake: latch opc, a, b, cin and id; rr_ptr <= ~id; go to EXEC. With no valid high, stay in IDLE.
- EXEC (1 cycle): compute the result from the latched operands, register rsp_data, rsp_zer and rsp_neg, set rsp_valid=1, go to RESP.
- RESP: rsp_* held stable while rsp_valid=1 and rsp_ready=0. On rsp_valid & rsp_ready: rsp_valid <= 0, go to IDLE. rsp_data and flags keep their last value.
- Latency and throughput:
  - Request handshake in cycle T gives rsp_valid high in cycle T+2.
  - Peak throughput is one operation per 3 cycles.
  - A new request is not accepted in the same cycle as a response handshake; it is accepted the cycle after.
- Opcodes (all results modulo 2^16, carry-out discarded):
  - 000: a+b+cin
  - 001: a+1
  - 010: signed max(a,b); if a==b (signed), result is a
  - 011: a+(b logical-shift-right 1)
  - 100: a&b
  - 101: a|b
  - 110: ~a
  - 111: 0
- cin is ignored for every opcode except 000.
- Flags: rsp_zer = (rsp_data==16'h0000); rsp_neg = rsp_data[15]. Both are registered with the data.
- Boundary cases:
  - A requester dropping valid while not granted is legal.
  - Valids arriving during EXEC/RESP wait; ready stays 0.
  - A requester whose valid stays high across its own response may win again only per the arbitration rule.
  - Reset asserted in EXEC or RESP returns to the reset state immediately (asynchronous).

Decomposition:
- Shared package alu_pkg holds:
  - localparams for the 8 opcodes (OP_ADD, OP_INC, OP_SMAX, OP_ADDHALF, OP_AND, OP_OR, OP_NOT, OP_ZERO)
  - the state encoding typedef (IDLE/EXEC/RESP)
  - DW default
- Sub-module alu_exec: purely combinational opcode evaluation (opc, a, b, cin -> result, zer, neg), instantiated once.
- Arbitration, FSM and response registers live in alu_arbiter.

Test Plan:
- req0 only: opc=000, a=16'h7FFF, b=16'h0001, cin=1 -> rsp at T+2: id=0, data=16'h8001, zer=0, neg=1.
- Both valid from reset, RR_EN=1, rsp_ready=1:
  - req0: opc=100, a=F0F0, b=FF00
  - req1: opc=110, a=0000
  - Expected: req0 first (data=F000), then req1 (data=FFFF, neg=1), alternating while both stay valid.
- RR_EN=0, both valid continuously -> req1_ready never asserts, every rsp_id=0.
- opc=010, a=16'hFFFE (-2), b=16'h0003 -> data=0003. Then opc=011, a=0010, b=8001 -> data=4010. Then opc=111 -> data=0000, zer=1.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_data, rsp_id and flags stay stable, both req_ready=0, busy=1. Release -> IDLE, next request accepted the following cycle.
- Reset mid-op: assert rst_n=0 during EXEC -> rsp_valid=0, busy=0, rsp_data=0 immediately. After release, no stale response appears and rr_ptr=0.
